// File: rtl/stream_reorder_pipe.sv
// stream_reorder_pipe
//   Collects NUM_BEATS input words into one wide group (first beat lands in
//   the MSBs, like {beat0, beat1, ...}), applies a run-time selected streaming
//   reorder ({>>N} identity or {<<N} slice reversal, N = 1/8/16/32), and hands
//   the result to a wide-word consumer over valid/ready.
//
// Parameters
//   DATA_W     beat width, multiple of 32
//   NUM_BEATS  beats per group, >= 1 (OUT_W = DATA_W*NUM_BEATS)
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   beat handshake; in_data beat, in_last group terminator
//   mode_dir            0 = {>>} identity, 1 = {<<} slice reversal
//   mode_slice          00 = 1b, 01 = 8b, 10 = 16b, 11 = 32b slices
//   out_valid/out_ready group handshake; out_data reordered group
//
// Optional feature macro: STREAM_REORDER_FLUSH_EN
//   When defined, a beat accepted with in_last = 1 closes the group early; the
//   unfilled low-order beats read as zero. When undefined, in_last is ignored.
module stream_reorder_pipe #(
  parameter int DATA_W    = 32,
  parameter int NUM_BEATS = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_W-1:0]             in_data,
  input  logic                          in_last,
  input  logic                          mode_dir,
  input  logic [1:0]                    mode_slice,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_W*NUM_BEATS-1:0]   out_data
);

  localparam int OUT_W = DATA_W * NUM_BEATS;
  localparam int CNT_W = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;

  typedef enum logic {COLLECT, EMIT} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   beat_cnt;
  logic [OUT_W-1:0]   buffer;
  logic               mode_dir_q;
  logic [1:0]         mode_slice_q;

  logic               accept;
  logic               last_beat;
  logic               group_done;
  logic               dir_eff;
  logic [1:0]         slice_eff;
  logic [OUT_W-1:0]   buffer_next;
  logic [OUT_W-1:0]   group_data;

  // {<<N}: slice k moves to slice OUT_W/N-1-k. {>>N} is identity for any N.
  function automatic logic [OUT_W-1:0] stream_fn(input logic [OUT_W-1:0] v,
                                                 input logic dir,
                                                 input logic [1:0] sl);
    logic [OUT_W-1:0] r;
    r = v;
    if (dir) begin
      case (sl)
        2'b00: for (int i = 0; i < OUT_W; i++)
                 r[OUT_W-1-i] = v[i];
        2'b01: for (int k = 0; k < OUT_W/8; k++)
                 r[(OUT_W/8-1-k)*8 +: 8] = v[k*8 +: 8];
        2'b10: for (int k = 0; k < OUT_W/16; k++)
                 r[(OUT_W/16-1-k)*16 +: 16] = v[k*16 +: 16];
        default: for (int k = 0; k < OUT_W/32; k++)
                 r[(OUT_W/32-1-k)*32 +: 32] = v[k*32 +: 32];
      endcase
    end
    return r;
  endfunction

  // Datapath: mode is taken live on beat 0 and from the held copy afterwards,
  // so the whole group is reordered with the beat-0 mode.
  always_comb begin
    last_beat   = (beat_cnt == CNT_W'(NUM_BEATS - 1));
    dir_eff     = (beat_cnt == '0) ? mode_dir   : mode_dir_q;
    slice_eff   = (beat_cnt == '0) ? mode_slice : mode_slice_q;
    // Shift by DATA_W also covers NUM_BEATS = 1 (old content fully shifted out).
    buffer_next = (buffer << DATA_W) | OUT_W'(in_data);
`ifdef STREAM_REORDER_FLUSH_EN
    // Early close: push the received beats up to the MSBs, zeros below.
    group_data  = last_beat ? buffer_next
                            : buffer_next << (DATA_W * (NUM_BEATS - 1 - int'(beat_cnt)));
`else
    group_data  = buffer_next;
`endif
  end

`ifndef STREAM_REORDER_FLUSH_EN
  logic unused_in_last;
  assign unused_in_last = in_last;
`endif

  // Next-state and handshake outputs.
  always_comb begin
    state_d    = state_q;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    accept     = 1'b0;
    group_done = 1'b0;
    case (state_q)
      COLLECT: begin
        in_ready = 1'b1;
        accept   = in_valid;
`ifdef STREAM_REORDER_FLUSH_EN
        group_done = accept && (last_beat || in_last);
`else
        group_done = accept && last_beat;
`endif
        if (group_done) state_d = EMIT;
      end
      EMIT: begin
        out_valid = 1'b1;
        if (out_ready) state_d = COLLECT;
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= COLLECT;
      beat_cnt     <= '0;
      buffer       <= '0;
      out_data     <= '0;
      mode_dir_q   <= 1'b0;
      mode_slice_q <= 2'b00;
    end else begin
      state_q <= state_d;
      if (accept) begin
        buffer <= buffer_next;
        if (beat_cnt == '0) begin
          mode_dir_q   <= mode_dir;
          mode_slice_q <= mode_slice;
        end
        if (group_done) begin
          beat_cnt <= '0;
          out_data <= stream_fn(group_data, dir_eff, slice_eff);
        end else begin
          beat_cnt <= beat_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_stream_reorder_pipe.sv
// Scoreboard bench for stream_reorder_pipe (default parameters).
module tb_stream_reorder_pipe;

  localparam int DW = 32;
  localparam int NB = 2;
  localparam int OW = DW * NB;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          in_last;
  logic          mode_dir;
  logic [1:0]    mode_slice;
  logic          out_valid;
  logic          out_ready;
  logic [OW-1:0] out_data;

  stream_reorder_pipe #(.DATA_W(DW), .NUM_BEATS(NB)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .mode_dir(mode_dir), .mode_slice(mode_slice),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_acc_cyc = -10;
  bit rand_rdy = 1'b0;
  logic [OW-1:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: place beats MSB-first (missing beats are zero), then for a
  // left stream cut into N-bit slices LSB-first and rebuild with the first
  // slice cut ending up on top.
  function automatic logic [OW-1:0] model(input logic [DW-1:0] b[$], input bit dir,
                                          input logic [1:0] sl);
    logic [OW-1:0] v, r, mask;
    logic [OW-1:0] s[$];
    int n;
    v = '0;
    for (int i = 0; i < b.size(); i++) v[(NB-1-i)*DW +: DW] = b[i];
    if (!dir) return v;
    n = (sl == 2'b00) ? 1 : (sl == 2'b01) ? 8 : (sl == 2'b10) ? 16 : 32;
    mask = (OW'(1) << n) - 1;
    for (int k = 0; k < OW/n; k++) s.push_back((v >> (k*n)) & mask);
    r = '0;
    foreach (s[k]) r = (r << n) | s[k];
    return r;
  endfunction

  task automatic fail_timeout(input string what);
    checks++; errors++;
    $display("FAIL %s: timed out waiting, required DUT progress", what);
  endtask

  // Called at a negedge; returns at the negedge after acceptance.
  task automatic send_beat(input logic [DW-1:0] d, input bit dir, input logic [1:0] sl,
                           input bit last, input bit is_final, input logic [OW-1:0] expv);
    int n = 0;
    in_valid = 1'b1; in_data = d; mode_dir = dir; mode_slice = sl; in_last = last;
    while (!in_ready && n < 200) begin @(negedge clk); n++; end
    if (!in_ready) begin fail_timeout("beat_accept"); in_valid = 1'b0; return; end
    @(posedge clk); #1;
    if (is_final) begin exp_q.push_back(expv); last_acc_cyc = cyc; end
    @(negedge clk);
    // Garbage on idle inputs must not disturb the DUT.
    in_valid = 1'b0; in_data = $urandom; in_last = $urandom; 
    mode_dir = $urandom; mode_slice = 2'($urandom);
  endtask

  task automatic send_group(input logic [DW-1:0] b[$], input bit dir, input logic [1:0] sl,
                            input bit perturb, input bit gaps);
    logic [OW-1:0] e;
    e = model(b, dir, sl);
    for (int i = 0; i < b.size(); i++) begin
      bit d; logic [1:0] s;
      d = dir; s = sl;
      if (perturb && i > 0) begin d = ~dir; s = sl + 2'd1; end
      if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
      send_beat(b[i], d, s, 1'b0, i == b.size()-1, e);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 500) begin @(negedge clk); n++; end
    if (exp_q.size() != 0) fail_timeout("drain");
  endtask

  task automatic set_ready(input bit v);
    @(posedge clk); #1 out_ready = v;
    @(negedge clk);
  endtask

  // out_ready changes only just after posedge so it is stable at negedge.
  always @(posedge clk) begin
    #1;
    if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
  end

  // Monitor: compare/pop on each handshake, plus stability and latency checks.
  logic          prev_valid = 1'b0, prev_ready = 1'b0;
  logic [OW-1:0] prev_data = '0;
  always @(negedge clk) begin
    if (!rst) begin
      if (prev_valid && !prev_ready) begin
        checks++;
        if (!out_valid || out_data !== prev_data) begin
          errors++;
          $display("FAIL hold_stable: valid=%0b data=%h required valid=1 data=%h",
                   out_valid, out_data, prev_data);
        end
      end
      if (out_valid && !prev_valid) begin
        // Rise observed in the cycle right after the final-beat accept edge.
        checks++;
        if (cyc != last_acc_cyc) begin
          errors++;
          $display("FAIL latency: out_valid rose in cycle %0d, required %0d", cyc, last_acc_cyc);
        end
      end
      if (out_valid) begin
        checks++;
        if (in_ready !== 1'b0) begin
          errors++;
          $display("FAIL in_ready_emit: in_ready=%0b required 0", in_ready);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_out: got %h, required no output", out_data);
        end else begin
          logic [OW-1:0] e;
          e = exp_q.pop_front();
          if (out_data !== e) begin
            errors++;
            $display("FAIL out_data: got %h required %h", out_data, e);
          end
        end
      end
    end
    prev_valid = out_valid; prev_ready = out_ready; prev_data = out_data;
  end

  task automatic check_reset_state(input string tag);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== '0) begin
      errors++;
      $display("FAIL %s: in_ready=%0b out_valid=%0b out_data=%h required 1 0 0",
               tag, in_ready, out_valid, out_data);
    end
  endtask

  initial begin
    logic [DW-1:0] b[$];
    logic [OW-1:0] hold;
    int n;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    mode_dir = 1'b0; mode_slice = 2'b00; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_reset_state("reset_state");

    // Directed vectors.
    b = '{32'h172A7FFF, 32'hFF7F2A17}; send_group(b, 1'b1, 2'b01, 1'b0, 1'b0); drain();
    b = '{32'h172A7FFF, 32'hFF7F2A17}; send_group(b, 1'b0, 2'b01, 1'b0, 1'b0); drain();
    b = '{32'h00000001, 32'h00000000}; send_group(b, 1'b1, 2'b00, 1'b0, 1'b0); drain();
    b = '{32'h11112222, 32'h33334444}; send_group(b, 1'b1, 2'b10, 1'b0, 1'b0); drain();
    b = '{32'h11112222, 32'h33334444}; send_group(b, 1'b1, 2'b11, 1'b0, 1'b0); drain();

    // Backpressure: 5 stalled cycles, with the mode changed after beat 0.
    set_ready(1'b0);
    b = '{32'h11112222, 32'h33334444}; send_group(b, 1'b1, 2'b10, 1'b1, 1'b0);
    n = 0;
    while (!out_valid && n < 20) begin @(negedge clk); n++; end
    if (!out_valid) fail_timeout("bp_valid");
    hold = out_data;
    repeat (5) begin
      @(negedge clk);
      checks++;
      if (out_data !== hold || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL backpressure: data=%h valid=%0b in_ready=%0b required %h 1 0",
                 out_data, out_valid, in_ready, hold);
      end
    end
    set_ready(1'b1);
    drain();

    // Reset after beat 0 discards the partial group.
    send_beat(32'h12345678, 1'b1, 2'b01, 1'b0, 1'b0, '0);
    rst = 1'b1; @(negedge clk); rst = 1'b0; @(negedge clk);
    check_reset_state("reset_mid_group");
    b = '{32'hAAAAAAAA, 32'h55555555}; send_group(b, 1'b0, 2'b11, 1'b0, 1'b0); drain();

    // in_last on beat 0.
`ifdef STREAM_REORDER_FLUSH_EN
    b = '{32'h172A7FFF};
    send_beat(32'h172A7FFF, 1'b1, 2'b01, 1'b1, 1'b1, model(b, 1'b1, 2'b01));
    drain();
`else
    send_beat(32'h172A7FFF, 1'b1, 2'b01, 1'b1, 1'b0, '0);
    repeat (4) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL no_flush: out_valid=%0b required 0", out_valid);
      end
    end
    b = '{32'h172A7FFF, 32'hFF7F2A17};
    send_beat(32'hFF7F2A17, 1'b0, 2'b00, 1'b0, 1'b1, model(b, 1'b1, 2'b01));
    drain();
`endif

    // Randomized groups with random backpressure, gaps and mode perturbation.
    rand_rdy = 1'b1;
    for (int g = 0; g < 40; g++) begin
      b = {};
      for (int i = 0; i < NB; i++) b.push_back($urandom);
      send_group(b, 1'($urandom), 2'($urandom), 1'($urandom), 1'b1);
    end
    drain();
    rand_rdy = 1'b0;
    set_ready(1'b1);
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
